filt_out_buffer: RTL

Output buffering stage directly downstream of the filter core (myfir). Captures every filter output sample qualified by the filter's VOUT strobe; the filter has no backpressure. Presents samples to the consumer (data sink / serializer) with a valid/ready handshake. Flags lost samples with a sticky overflow flag and reports fill level.

---
 rtl/filt_out_buffer_if.sv | 35 +++
 rtl/filt_out_buffer.sv | 108 ++++++++++
 2 files changed

// File: rtl/filt_out_buffer_if.sv
// Sample/handshake bundle between the filter output buffer and its neighbours.
// FOB_PEAK_EN adds the PEAK statistic signal.
interface filt_out_buffer_if #(
  parameter int NB = 12,
  parameter int AW = 3
);
  logic [NB-1:0] DIN;
  logic          VIN;
  logic [NB-1:0] DOUT;
  logic          VOUT;
  logic          READY;
  logic [AW:0]   LEVEL;
  logic          OVF;
  logic          CLR_STAT;
`ifdef FOB_PEAK_EN
  logic [NB-1:0] PEAK;
`endif

  // The buffer itself takes the slave view; the filter/consumer side is master.
  modport slave (
    input  DIN, VIN, READY, CLR_STAT,
    output DOUT, VOUT, LEVEL, OVF
`ifdef FOB_PEAK_EN
    , output PEAK
`endif
  );

  modport master (
    output DIN, VIN, READY, CLR_STAT,
    input  DOUT, VOUT, LEVEL, OVF
`ifdef FOB_PEAK_EN
    , input PEAK
`endif
  );
endinterface

// File: rtl/filt_out_buffer.sv
// First-word-fall-through FIFO behind the FIR core with sticky overflow flag.
// Define FOB_PEAK_EN to add a running |sample| peak statistic on PEAK.
module filt_out_buffer #(
  parameter int NB    = 12,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic CLK,
  input logic RST,
  filt_out_buffer_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [NB-1:0] mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          ovf_reg;

  logic vout;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign vout = (count_reg != '0);
  assign full = (count_reg == FULL_CNT);
  assign pop  = vout & bus.READY;
  // A full buffer still accepts a sample when the head leaves in the same cycle.
  assign push = bus.VIN & (~full | pop);
  assign drop = bus.VIN & full & ~pop;

  assign bus.VOUT  = vout;
  assign bus.DOUT  = vout ? mem_reg[rd_ptr_reg] : '0;
  assign bus.LEVEL = count_reg;
  assign bus.OVF   = ovf_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge CLK) begin
        if (!RST && push && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= bus.DIN;
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      // An overflow in the clearing cycle must not be lost.
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (bus.CLR_STAT) begin
        ovf_reg <= 1'b0;
      end
    end
  end

`ifdef FOB_PEAK_EN
  logic [NB-1:0] peak_reg;
  logic [NB-1:0] abs_din;
  logic [NB-1:0] most_neg;
  logic [NB-1:0] most_pos;

  assign most_neg = {1'b1, {(NB-1){1'b0}}};
  assign most_pos = {1'b0, {(NB-1){1'b1}}};

  // Magnitude in NB bits; the most negative code saturates.
  always_comb begin
    abs_din = bus.DIN;
    if (bus.DIN == most_neg) begin
      abs_din = most_pos;
    end else if (bus.DIN[NB-1]) begin
      abs_din = -bus.DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      peak_reg <= '0;
    end else if (bus.CLR_STAT) begin
      peak_reg <= push ? abs_din : '0;
    end else if (push && (abs_din > peak_reg)) begin
      peak_reg <= abs_din;
    end
  end

  assign bus.PEAK = peak_reg;
`endif
endmodule
